// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the MEM-stage controller: FSM encoding,
// address defaults and the poison word returned by an aborted access.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    localparam logic [31:0] MEM_BASE_DEF       = 32'd1024;
    localparam int          ADDR_W_DEF         = 16;
    localparam int          TIMEOUT_CYCLES_DEF = 64;
    localparam logic [31:0] TIMEOUT_POISON     = 32'hDEADBEEF;

    // Byte address relative to the memory window, as a word index (wraps mod 2^32).
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                               input logic [31:0] base);
        return (byte_addr - base) >> 2;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a bubble loads all fields with zero so a frozen
// memory instruction never writes back twice.
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        bubble,
    input  logic        WB_en_d,
    input  logic        MEM_R_EN_d,
    input  logic [31:0] PC_d,
    input  logic [31:0] ALU_result_d,
    input  logic [31:0] MEM_result_d,
    input  logic [4:0]  Dest_d,
    output logic        WB_en,
    output logic        MEM_R_EN,
    output logic [31:0] PC,
    output logic [31:0] ALU_result,
    output logic [31:0] MEM_result,
    output logic [4:0]  Dest
);

    always_ff @(posedge clk) begin
        if (!rst || bubble) begin
            WB_en      <= 1'b0;
            MEM_R_EN   <= 1'b0;
            PC         <= '0;
            ALU_result <= '0;
            MEM_result <= '0;
            Dest       <= '0;
        end else begin
            WB_en      <= WB_en_d;
            MEM_R_EN   <= MEM_R_EN_d;
            PC         <= PC_d;
            ALU_result <= ALU_result_d;
            MEM_result <= MEM_result_d;
            Dest       <= Dest_d;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: req/ack handshake to a multi-cycle data memory with
// upstream freeze. Optional WAIT timeout enabled by defining MEM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | pass-through; an access latches address/data and freezes upstream
// WAIT  | mem_req held until mem_ack (or timeout abort)
// DONE  | MEM/WB loads the instruction with captured read data, then IDLE
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter logic [31:0] MEM_BASE       = MEM_BASE_DEF,
    parameter int          ADDR_W         = ADDR_W_DEF,
    parameter int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WB_en_in,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic [31:0]       PC_in,
    input  logic [31:0]       ALU_result_in,
    input  logic [31:0]       ST_val_in,
    input  logic [4:0]        Dest_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              freeze,
    output logic              WB_en,
    output logic              MEM_R_EN,
    output logic [31:0]       PC,
    output logic [31:0]       ALU_result,
    output logic [31:0]       MEM_result,
    output logic [4:0]        Dest,
    output logic              mem_err
);

    mem_state_e  state, state_nxt;
    logic        access;
    logic        load_fwd;
    logic        issue;
    logic        timeout_hit;
    logic [31:0] word_idx;
    logic [31:0] rdata_q;
    logic [31:0] mem_result_d;
    logic [31:ADDR_W] addr_unused;

    generate
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    assign access      = MEM_R_EN_in | MEM_W_EN_in;
    assign load_fwd    = MEM_R_EN_in & ~MEM_W_EN_in;  // write wins over read
    assign word_idx    = word_index(ALU_result_in, MEM_BASE);
    assign addr_unused = word_idx[31:ADDR_W];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (access) state_nxt = WAIT;
            WAIT:    if (mem_ack || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        freeze  = 1'b0;
        mem_req = 1'b0;
        issue   = 1'b0;
        case (state)
            IDLE: begin
                freeze = access;
                issue  = access;
            end
            WAIT: begin
                freeze  = 1'b1;
                mem_req = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
        end else if (issue) begin
            mem_addr  <= word_idx[ADDR_W-1:0];
            mem_wdata <= ST_val_in;
            mem_we    <= MEM_W_EN_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (mem_req && mem_ack) begin
            rdata_q <= mem_rdata;
        end else if (timeout_hit) begin
            rdata_q <= TIMEOUT_POISON;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             err_q;

    // Terminal count reached in the last allowed WAIT cycle; an ack there wins.
    assign timeout_hit = mem_req && !mem_ack && (tmo_cnt == '0);
    assign mem_err     = err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= timeout_hit;
            if (issue) begin
                tmo_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
            end else if (mem_req && (tmo_cnt != '0)) begin
                tmo_cnt <= tmo_cnt - CNT_W'(1);
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign mem_err     = 1'b0;
`endif

    assign mem_result_d = ((state == DONE) && load_fwd) ? rdata_q : 32'd0;

    mem_wb_reg u_mem_wb (
        .clk          (clk),
        .rst          (rst),
        .bubble       (freeze),
        .WB_en_d      (WB_en_in),
        .MEM_R_EN_d   (load_fwd),
        .PC_d         (PC_in),
        .ALU_result_d (ALU_result_in),
        .MEM_result_d (mem_result_d),
        .Dest_d       (Dest_in),
        .WB_en        (WB_en),
        .MEM_R_EN     (MEM_R_EN),
        .PC           (PC),
        .ALU_result   (ALU_result),
        .MEM_result   (MEM_result),
        .Dest         (Dest)
    );

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage controller on the consumer side of the EX/MEM pipeline register.
- Takes WB_en, MEM_R_EN, MEM_W_EN, ALU_result, ST_val, Dest and PC from the EX/MEM register.
- Runs a req/ack handshake with a multi-cycle data memory and raises freeze to stall upstream stages while an access is in flight.
- Loads the MEM/WB pipeline register with either the memory read data or the passed-through ALU result.

Parameters:
- MEM_BASE, 1024: byte address subtracted from ALU_result before word indexing.
- ADDR_W, 16: word-address width driven to memory.
- TIMEOUT_CYCLES, 64: WAIT-state cycle limit. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- WB_en_in  in  1  writeback enable from EX/MEM.
- MEM_R_EN_in  in  1  load request.
- MEM_W_EN_in  in  1  store request.
- PC_in  in  32  instruction PC.
- ALU_result_in  in  32  effective byte address, or arithmetic result.
- ST_val_in  in  32  store data.
- Dest_in  in  5  destination register.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  store data.
- mem_ack  in  1  memory completion, 1-cycle pulse.
- mem_rdata  in  32  read data, valid with mem_ack.
- freeze  out  1  hold PC, IF/ID, ID/EX and EX/MEM registers.
- WB_en  out  1  MEM/WB writeback enable.
- MEM_R_EN  out  1  MEM/WB writeback-mux select.
- PC  out  32  MEM/WB PC.
- ALU_result  out  32  MEM/WB ALU result.
- MEM_result  out  32  MEM/WB load data.
- Dest  out  5  MEM/WB destination register.
- mem_err  out  1  timeout error pulse. Tied 0 without MEM_TIMEOUT_EN.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - Every output goes to 0, including mem_req, freeze and all MEM/WB fields.
  - A reset during WAIT abandons the access; a late mem_ack is ignored.
- Define access = MEM_R_EN_in | MEM_W_EN_in.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If access=1: freeze=1 combinationally in this cycle.
  - At the clock edge, register mem_addr = (ALU_result_in - MEM_BASE) >> 2, truncated to ADDR_W; mem_wdata = ST_val_in; mem_we = MEM_W_EN_in. Then go to WAIT.
  - If access=0: freeze=0 and the MEM/WB fields load directly from the inputs (pass-through, 1-cycle latency).
- WAIT:
  - mem_req=1 and freeze=1. mem_addr, mem_wdata and mem_we are stable.
  - On mem_ack=1: capture mem_rdata into an internal register and go to DONE. An ack in the first WAIT cycle is legal.
  - mem_ack in IDLE or DONE is ignored.
- DONE:
  - freeze=0 and mem_req=0.
  - MEM/WB loads the EX/MEM inputs. MEM_result = captured read data for loads, 0 for stores.
  - Next state is IDLE unconditionally. The still-present access inputs must not retrigger an access in DONE.
- While freeze=1, MEM/WB loads a bubble: WB_en=0 and MEM_R_EN=0, other fields 0. This prevents duplicate writeback.
- Minimum memory-instruction latency is 3 cycles (IDLE, WAIT, DONE); each extra WAIT cycle adds 1.
- If MEM_R_EN_in and MEM_W_EN_in are both 1, the write takes priority and MEM_R_EN is forwarded as 0.
- Address arithmetic is modulo 2^32 before the shift. No range check.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- With the macro:
  - A counter runs in WAIT.
  - When WAIT has lasted TIMEOUT_CYCLES cycles without mem_ack, the access is aborted: mem_err pulses for 1 cycle and the FSM goes to DONE with captured data = 32'hDEADBEEF.
  - An ack arriving in that same final cycle wins and mem_err stays 0.
- Without the macro: no counter, mem_err is constant 0, and WAIT lasts indefinitely.

Decomposition:
- Package mem_stage_pkg holds:
  - the state encoding (IDLE/WAIT/DONE);
  - the MEM_BASE default;
  - the ADDR_W default;
  - the timeout poison constant 32'hDEADBEEF.
- Sub-module mem_wb_reg: the MEM/WB pipeline register with a bubble input.
  - Synchronous active-low rst.
  - Holds the WB_en, MEM_R_EN, PC, ALU_result, MEM_result and Dest fields.
  - Instantiated once.

Test Plan:
- Reset: hold rst=0 for 2 cycles during WAIT, then release → mem_req=0, freeze=0, all outputs 0; a late mem_ack does not change any output.
- ALU op pass-through: WB_en_in=1, access=0, ALU_result_in=0x55, Dest_in=7 → next cycle WB_en=1, ALU_result=0x55, Dest=7, freeze never asserted.
- Load with 3-cycle ack delay: MEM_R_EN_in=1, ALU_result_in=1028 → mem_addr=1, mem_we=0, mem_req high 3 cycles; ack with mem_rdata=0xCAFE → DONE cycle, MEM_result=0xCAFE, MEM_R_EN=1, WB_en=1 exactly once; freeze high for 4 cycles.
- Store with same-cycle ack: MEM_W_EN_in=1, ALU_result_in=1032, ST_val_in=0x1234 → mem_addr=2, mem_wdata=0x1234, mem_we=1; 1 WAIT cycle, then DONE; WB_en=0.
- Back-to-back load then ALU op → a single DONE cycle, no second mem_req, and the ALU op completes the cycle after DONE.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4 and no ack → mem_err pulses once after 4 WAIT cycles, MEM_result=0xDEADBEEF, then IDLE.
